// File: rtl/wptr_full_level_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and a depth helper.
// The functions work on a fixed 32-bit container. Callers zero-extend
// narrower pointers on the way in and truncate on the way out.
package wptr_full_level_pkg;

  localparam int unsigned PtrMaxW = 32;

  // Number of memory entries for a given address width.
  function automatic int unsigned depth_of(input int unsigned addrsize);
    return 32'd1 << addrsize;
  endfunction

  function automatic logic [PtrMaxW-1:0] bin2gray(input logic [PtrMaxW-1:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

  // XOR prefix from the MSB down. Zero-extended upper bits leave the result unchanged.
  function automatic logic [PtrMaxW-1:0] gray2bin(input logic [PtrMaxW-1:0] gray);
    logic [PtrMaxW-1:0] bin;
    bin[PtrMaxW-1] = gray[PtrMaxW-1];
    for (int i = PtrMaxW - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_ptr_gray.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Ports:
//   clk_i  - destination-domain clock
//   rst_ni - asynchronous active-low reset; clears every stage
//   d_i    - Gray pointer from the source domain
//   q_o    - synchronised pointer (last stage)
module sync_ptr_gray #(
  parameter int unsigned Width  = 5,
  parameter int unsigned Stages = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] sync_q [Stages];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Stages; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < Stages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/wptr_full_level.sv
// Write-domain pointer and status controller for the asynchronous FIFO.
// It keeps binary and Gray write pointers, synchronises the read Gray pointer,
// and registers the full, almost-full, fill-level and sticky overflow flags.
// Ports:
//   wclk, wrst_n  - write clock, asynchronous active-low reset
//   winc          - write request, accepted when wfull is low
//   wclr_ovf      - clears the sticky overflow flag
//   rptr_gray     - read-domain Gray pointer (asynchronous)
//   waddr         - memory write address
//   wptr          - registered Gray write pointer sent to the read side
//   wen           - combinational memory write enable
//   wfull         - registered full flag
//   walmost_full  - registered wlevel >= AFULL_THRESH
//   wlevel        - registered pessimistic occupancy, 0..DEPTH
//   wovf          - sticky overflow (write attempted while full)
module wptr_full_level
  import wptr_full_level_pkg::*;
#(
  parameter int unsigned ADDRSIZE     = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned AFULL_THRESH = 2**ADDRSIZE - 4
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic                wclr_ovf,
  input  logic [ADDRSIZE:0]   rptr_gray,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wen,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
);

  localparam int unsigned PtrW = ADDRSIZE + 1;
  localparam logic [PtrW-1:0] AfullThr = PtrW'(AFULL_THRESH);

  logic [PtrW-1:0] wq_rptr;
  logic [PtrW-1:0] wq_rbin;
  logic [PtrW-1:0] wbin_q, wbin_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] level_q, level_d;
  logic            wfull_q, wfull_d;
  logic            wafull_q, wafull_d;
  logic            wovf_q, wovf_d;

  sync_ptr_gray #(
    .Width  (PtrW),
    .Stages (SYNC_STAGES)
  ) u_sync (
    .clk_i  (wclk),
    .rst_ni (wrst_n),
    .d_i    (rptr_gray),
    .q_o    (wq_rptr)
  );

  assign wen     = winc & ~wfull_q;
  assign wq_rbin = PtrW'(gray2bin(PtrMaxW'(wq_rptr)));

  always_comb begin
    wbin_d   = wbin_q + PtrW'(wen);
    wptr_d   = PtrW'(bin2gray(PtrMaxW'(wbin_d)));
    // Full when the write pointer leads the read pointer by exactly DEPTH:
    // in Gray code that is the top two bits inverted, the rest equal.
    wfull_d  = (wptr_d == {~wq_rptr[ADDRSIZE:ADDRSIZE-1], wq_rptr[ADDRSIZE-2:0]});
    level_d  = wbin_d - wq_rbin;
    wafull_d = (level_d >= AfullThr);
    wovf_d   = wovf_q;
    if (winc && wfull_q) begin
      wovf_d = 1'b1;
    end else if (wclr_ovf) begin
      wovf_d = 1'b0;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      level_q  <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      level_q  <= level_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = wafull_q;
  assign wlevel       = level_q;
  assign wovf         = wovf_q;

endmodule
